// File: rtl/rf_wb_arbiter_pkg.sv
// Shared defaults and requester ids for the register-file writeback arbiter.
package rf_wb_arbiter_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 5;
    localparam int unsigned DEF_DATA_WIDTH = 64;
    localparam int unsigned DEF_NUM_REGS   = 32;

    typedef enum logic {
        REQ_EXU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_e;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus bundle: EXU/LSU requests, register-file write port, scoreboard.
interface rf_wb_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned NUM_REGS   = 32
);
    logic                  exu_valid;
    logic                  exu_ready;
    logic [ADDR_WIDTH-1:0] exu_waddr;
    logic [DATA_WIDTH-1:0] exu_wdata;
    logic                  lsu_valid;
    logic                  lsu_ready;
    logic [ADDR_WIDTH-1:0] lsu_waddr;
    logic [DATA_WIDTH-1:0] lsu_wdata;
    logic                  rf_wen;
    logic [ADDR_WIDTH-1:0] rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;
    logic                  sb_set_valid;
    logic [ADDR_WIDTH-1:0] sb_set_addr;
    logic [NUM_REGS-1:0]   sb_busy;

    // Requester/decoder side.
    modport master (
        output exu_valid, exu_waddr, exu_wdata,
        output lsu_valid, lsu_waddr, lsu_wdata,
        output sb_set_valid, sb_set_addr,
        input  exu_ready, lsu_ready,
        input  rf_wen, rf_waddr, rf_wdata, sb_busy
    );

    // Arbiter side.
    modport slave (
        input  exu_valid, exu_waddr, exu_wdata,
        input  lsu_valid, lsu_waddr, lsu_wdata,
        input  sb_set_valid, sb_set_addr,
        output exu_ready, lsu_ready,
        output rf_wen, rf_waddr, rf_wdata, sb_busy
    );
endinterface

// File: rtl/rf_wb_arbiter_scoreboard.sv
// Pending-write bitmap: set on reservation, clear when the write lands; set wins.
module rf_scoreboard
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned NUM_REGS   = DEF_NUM_REGS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_valid,
    input  logic [ADDR_WIDTH-1:0] set_addr,
    input  logic                  clr_valid,
    input  logic [ADDR_WIDTH-1:0] clr_addr,
    output logic [NUM_REGS-1:0]   busy
);

    logic [NUM_REGS-1:0] busy_next;

    always_comb begin
        busy_next = busy;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (clr_valid && (clr_addr == ADDR_WIDTH'(i))) busy_next[i] = 1'b0;
            // A new reservation on the clearing edge belongs to a new producer.
            if (set_valid && (set_addr == ADDR_WIDTH'(i))) busy_next[i] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_next;
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter (EXU/LSU) with registered RF write port and pending-write scoreboard.
// Build option RF_WB_FIXED_PRIO_EN: fixed LSU-over-EXU priority instead of round robin.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned NUM_REGS   = DEF_NUM_REGS
) (
    input logic           clk,
    input logic           rst_n,
    rf_wb_arbiter_if.slave bus
);

    logic                  exu_grant;
    logic                  lsu_grant;
    logic                  exu_fire;
    logic                  lsu_fire;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  wen_next;

`ifdef RF_WB_FIXED_PRIO_EN
    always_comb begin
        exu_grant = 1'b0;
        lsu_grant = 1'b0;
        if (bus.lsu_valid)      lsu_grant = 1'b1;
        else if (bus.exu_valid) exu_grant = 1'b1;
    end
`else
    req_id_e last_grant;
    req_id_e last_grant_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_grant <= REQ_LSU;
        else        last_grant <= last_grant_next;
    end

    always_comb begin
        exu_grant       = 1'b0;
        lsu_grant       = 1'b0;
        last_grant_next = last_grant;
        if (bus.exu_valid && bus.lsu_valid) begin
            if (last_grant == REQ_LSU) exu_grant = 1'b1;
            else                       lsu_grant = 1'b1;
        end else begin
            exu_grant = bus.exu_valid;
            lsu_grant = bus.lsu_valid;
        end
        if (exu_grant)      last_grant_next = REQ_EXU;
        else if (lsu_grant) last_grant_next = REQ_LSU;
    end
`endif

    assign bus.exu_ready = exu_grant;
    assign bus.lsu_ready = lsu_grant;
    assign exu_fire      = bus.exu_valid && exu_grant;
    assign lsu_fire      = bus.lsu_valid && lsu_grant;

    always_comb begin
        sel_addr = bus.exu_waddr;
        sel_data = bus.exu_wdata;
        if (lsu_fire) begin
            sel_addr = bus.lsu_waddr;
            sel_data = bus.lsu_wdata;
        end
    end

    // x0 transfers complete the handshake but never reach the register file.
    assign wen_next = (exu_fire || lsu_fire) && (sel_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rf_wen   <= 1'b0;
            bus.rf_waddr <= '0;
            bus.rf_wdata <= '0;
        end else begin
            bus.rf_wen <= wen_next;
            if (wen_next) begin
                bus.rf_waddr <= sel_addr;
                bus.rf_wdata <= sel_data;
            end
        end
    end

    rf_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_valid (bus.sb_set_valid),
        .set_addr  (bus.sb_set_addr),
        .clr_valid (bus.rf_wen),
        .clr_addr  (bus.rf_waddr),
        .busy      (bus.sb_busy)
    );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: expected RF writes queued at accept, compared on rf_wen.
module tb_rf_wb_arbiter;

    typedef struct packed {
        logic [4:0]  addr;
        logic [63:0] data;
    } wr_t;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;
    wr_t  exp_q[$];

    rf_wb_arbiter_if #(.ADDR_WIDTH(5), .DATA_WIDTH(64), .NUM_REGS(32)) bus ();

    rf_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(64), .NUM_REGS(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    task automatic drive_idle();
        bus.exu_valid    = 1'b0;
        bus.exu_waddr    = '0;
        bus.exu_wdata    = '0;
        bus.lsu_valid    = 1'b0;
        bus.lsu_waddr    = '0;
        bus.lsu_wdata    = '0;
        bus.sb_set_valid = 1'b0;
        bus.sb_set_addr  = '0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        drive_idle();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        @(posedge clk);
        @(posedge clk);
        #1;
        total_cnt += 5;
        if (bus.rf_wen !== 1'b0) $display("FAIL reset_wen got %0b want 0", bus.rf_wen); else pass_cnt++;
        if (bus.rf_waddr !== 5'd0) $display("FAIL reset_waddr got %0d want 0", bus.rf_waddr); else pass_cnt++;
        if (bus.rf_wdata !== 64'd0) $display("FAIL reset_wdata got %0h want 0", bus.rf_wdata); else pass_cnt++;
        if (bus.sb_busy !== 32'd0) $display("FAIL reset_busy got %0h want 0", bus.sb_busy); else pass_cnt++;
        if ({bus.exu_ready, bus.lsu_ready} !== 2'b00)
            $display("FAIL reset_ready got %0b want 00", {bus.exu_ready, bus.lsu_ready}); else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        wr_t w;
        @(posedge clk); #1;
        bus.exu_valid = 1'b1; bus.exu_waddr = 5'd5; bus.exu_wdata = 64'h1234;
        @(negedge clk);
        total_cnt += 2;
        if (bus.exu_ready !== 1'b1) $display("FAIL single_exu_ready got %0b want 1", bus.exu_ready); else pass_cnt++;
        if (bus.lsu_ready !== 1'b0) $display("FAIL single_lsu_ready got %0b want 0", bus.lsu_ready); else pass_cnt++;
        exp_q.push_back('{addr: 5'd5, data: 64'h1234});
        @(posedge clk); #1;
        bus.exu_valid = 1'b0;
        total_cnt++;
        if (bus.rf_wen !== 1'b1) $display("FAIL single_wen got %0b want 1", bus.rf_wen);
        else begin
            w = exp_q.pop_front();
            if ({bus.rf_waddr, bus.rf_wdata} !== {w.addr, w.data})
                $display("FAIL single_write got %0d:%0h want %0d:%0h", bus.rf_waddr, bus.rf_wdata, w.addr, w.data);
            else pass_cnt++;
        end
        @(posedge clk); #1;
        total_cnt += 2;
        if (bus.rf_wen !== 1'b0) $display("FAIL single_wen_drop got %0b want 0", bus.rf_wen); else pass_cnt++;
        if (bus.rf_waddr !== 5'd5) $display("FAIL single_addr_hold got %0d want 5", bus.rf_waddr); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        wr_t w;
        logic exp_exu;
        int   ne = 0;
        int   nl = 0;
        apply_reset();
        @(posedge clk); #1;
        bus.exu_valid = 1'b1; bus.exu_waddr = 5'd3; bus.exu_wdata = 64'hE000;
        bus.lsu_valid = 1'b1; bus.lsu_waddr = 5'd4; bus.lsu_wdata = 64'hB000;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
`ifdef RF_WB_FIXED_PRIO_EN
            exp_exu = 1'b0;
`else
            exp_exu = ((k % 2) == 0);
`endif
            total_cnt++;
            if ({bus.exu_ready, bus.lsu_ready} !== {exp_exu, ~exp_exu})
                $display("FAIL b2b_grant%0d got %0b want %0b", k, {bus.exu_ready, bus.lsu_ready}, {exp_exu, ~exp_exu});
            else pass_cnt++;
            if (bus.exu_ready) exp_q.push_back('{addr: bus.exu_waddr, data: bus.exu_wdata});
            if (bus.lsu_ready) exp_q.push_back('{addr: bus.lsu_waddr, data: bus.lsu_wdata});
            @(posedge clk); #1;
            if (bus.exu_ready) begin ne++; bus.exu_wdata = 64'hE000 + 64'(ne); end
            if (bus.lsu_ready) begin nl++; bus.lsu_wdata = 64'hB000 + 64'(nl); end
            if (k == 3) drive_idle();
            total_cnt++;
            if (bus.rf_wen !== 1'b1 || exp_q.size() == 0)
                $display("FAIL b2b_wen%0d got %0b want 1", k, bus.rf_wen);
            else begin
                w = exp_q.pop_front();
                if ({bus.rf_waddr, bus.rf_wdata} !== {w.addr, w.data})
                    $display("FAIL b2b_write%0d got %0d:%0h want %0d:%0h", k, bus.rf_waddr, bus.rf_wdata, w.addr, w.data);
                else pass_cnt++;
            end
        end
        @(posedge clk); #1;
        total_cnt++;
        if (bus.rf_wen !== 1'b0 || exp_q.size() != 0)
            $display("FAIL b2b_drain got wen %0b pending %0d want 0 0", bus.rf_wen, exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_x0_write();
        logic [31:0] busy_before;
        logic [4:0]  addr_before;
        busy_before = bus.sb_busy;
        addr_before = bus.rf_waddr;
        @(posedge clk); #1;
        bus.lsu_valid = 1'b1; bus.lsu_waddr = 5'd0; bus.lsu_wdata = 64'hFFFF;
        bus.sb_set_valid = 1'b1; bus.sb_set_addr = 5'd0;
        @(negedge clk);
        total_cnt++;
        if (bus.lsu_ready !== 1'b1) $display("FAIL x0_ready got %0b want 1", bus.lsu_ready); else pass_cnt++;
        @(posedge clk); #1;
        drive_idle();
        total_cnt += 3;
        if (bus.rf_wen !== 1'b0) $display("FAIL x0_wen got %0b want 0", bus.rf_wen); else pass_cnt++;
        if (bus.sb_busy !== busy_before) $display("FAIL x0_busy got %0h want %0h", bus.sb_busy, busy_before); else pass_cnt++;
        if (bus.rf_waddr !== addr_before) $display("FAIL x0_addr_hold got %0d want %0d", bus.rf_waddr, addr_before); else pass_cnt++;
    endtask

    task automatic test_scoreboard();
        wr_t w;
        @(posedge clk); #1;
        bus.sb_set_valid = 1'b1; bus.sb_set_addr = 5'd7;
        @(posedge clk); #1;
        bus.sb_set_valid = 1'b0;
        total_cnt++;
        if (bus.sb_busy !== 32'h80) $display("FAIL sb_set got %0h want 80", bus.sb_busy); else pass_cnt++;
        @(posedge clk); #1;
        bus.exu_valid = 1'b1; bus.exu_waddr = 5'd7; bus.exu_wdata = 64'hCAFE;
        @(negedge clk);
        if (bus.exu_ready) exp_q.push_back('{addr: 5'd7, data: 64'hCAFE});
        @(posedge clk); #1;
        bus.exu_valid = 1'b0;
        total_cnt += 2;
        if (bus.rf_wen !== 1'b1 || exp_q.size() == 0) $display("FAIL sb_wen got %0b want 1", bus.rf_wen);
        else begin
            w = exp_q.pop_front();
            if ({bus.rf_waddr, bus.rf_wdata} !== {w.addr, w.data})
                $display("FAIL sb_write got %0d:%0h want %0d:%0h", bus.rf_waddr, bus.rf_wdata, w.addr, w.data);
            else pass_cnt++;
        end
        if (bus.sb_busy[7] !== 1'b1) $display("FAIL sb_busy_during_wen got %0b want 1", bus.sb_busy[7]); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (bus.sb_busy[7] !== 1'b0) $display("FAIL sb_clear got %0b want 0", bus.sb_busy[7]); else pass_cnt++;
        // same-edge set and clear of register 7
        bus.sb_set_valid = 1'b1; bus.sb_set_addr = 5'd7;
        @(posedge clk); #1;
        bus.sb_set_valid = 1'b0;
        bus.exu_valid = 1'b1; bus.exu_waddr = 5'd7; bus.exu_wdata = 64'hBEEF;
        @(posedge clk); #1;
        bus.exu_valid = 1'b0;
        bus.sb_set_valid = 1'b1; bus.sb_set_addr = 5'd7;
        total_cnt++;
        if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 5'd7)
            $display("FAIL sb_same_wen got %0b:%0d want 1:7", bus.rf_wen, bus.rf_waddr);
        else pass_cnt++;
        @(posedge clk); #1;
        bus.sb_set_valid = 1'b0;
        total_cnt++;
        if (bus.sb_busy[7] !== 1'b1) $display("FAIL sb_set_wins got %0b want 1", bus.sb_busy[7]); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        bus.sb_set_valid = 1'b1; bus.sb_set_addr = 5'd9;
        @(posedge clk); #1;
        bus.sb_set_valid = 1'b0;
        bus.exu_valid = 1'b1; bus.exu_waddr = 5'd9; bus.exu_wdata = 64'h9999;
        @(posedge clk); #1;
        bus.exu_valid = 1'b0;
        total_cnt++;
        if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 5'd9)
            $display("FAIL mid_pending got %0b:%0d want 1:9", bus.rf_wen, bus.rf_waddr);
        else pass_cnt++;
        #1 rst_n = 1'b0;
        #1;
        total_cnt += 2;
        if (bus.rf_wen !== 1'b0) $display("FAIL mid_wen got %0b want 0", bus.rf_wen); else pass_cnt++;
        if (bus.sb_busy !== 32'd0) $display("FAIL mid_busy got %0h want 0", bus.sb_busy); else pass_cnt++;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (bus.rf_wen !== 1'b0) $display("FAIL mid_no_write%0d got %0b want 0", k, bus.rf_wen); else pass_cnt++;
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_x0_write();
        test_scoreboard();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
